// File: rtl/seq_phase_timer.sv
// -----------------------------------------------------------------------------
// seq_phase_timer
//
// A prescaled timer that drives an N-phase sequencer. Each phase lasts a
// programmable number of ticks. Two mode flops, hold and direction, are
// flipped by single-cycle toggle inputs. A synchronous clear overrides
// everything except the asynchronous reset.
//
// Optional feature macro: SEQ_PHASE_TIMER_LAP_EN
//   defined     : lap_cnt counts wraps and saturates at all-ones
//   not defined : lap_cnt is tied to zero and no lap flops exist
//
// Parameters
//   PRESCALE  clock cycles per tick, >= 1 (1 = tick on every RUN cycle)
//   NUM_PH    number of phases, >= 2
//   DWELL_W   width of each per-phase dwell field
//   LAP_W     width of the lap counter
//
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous reset, active-low
//   clr        in   synchronous clear; beats start and the toggles
//   start      in   leave IDLE (ignored in the other states)
//   tog_hold   in   each high cycle flips the hold mode flop
//   tog_dir    in   each high cycle flips the direction flop (0=fwd, 1=rev)
//   dwell_cfg  in   phase p dwell D at [p*DWELL_W +: DWELL_W]; phase = D+1 ticks
//   phase_idx  out  current phase (registered)
//   phase_oh   out  one-hot of phase_idx in RUN/HOLD, zero in IDLE
//   tick       out  prescaler terminal count while in RUN
//   wrap       out  one-cycle pulse the cycle after a phase wrap-around
//   busy       out  state is not IDLE
//   hold_st    out  state is HOLD
//   lap_cnt    out  saturating wrap count (zero when the feature is off)
// -----------------------------------------------------------------------------
module seq_phase_timer #(
    parameter int PRESCALE = 10,
    parameter int NUM_PH   = 4,
    parameter int DWELL_W  = 4,
    parameter int LAP_W    = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clr,
    input  logic                        start,
    input  logic                        tog_hold,
    input  logic                        tog_dir,
    input  logic [NUM_PH*DWELL_W-1:0]   dwell_cfg,
    output logic [$clog2(NUM_PH)-1:0]   phase_idx,
    output logic [NUM_PH-1:0]           phase_oh,
    output logic                        tick,
    output logic                        wrap,
    output logic                        busy,
    output logic                        hold_st,
    output logic [LAP_W-1:0]            lap_cnt
);

    localparam int PH_W  = $clog2(NUM_PH);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(NUM_PH - 1);

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [PRE_W-1:0]   pre_cnt_r;
    logic [DWELL_W-1:0] dw_cnt_r;
    logic [PH_W-1:0]    phase_idx_r;
    logic               hold_q_r;
    logic               dir_q_r;
    logic               wrap_r;

    logic               hold_nxt_s;
    logic               tick_s;
    logic [DWELL_W-1:0] dwell_sel_s;
    logic               advance_s;
    logic [PH_W-1:0]    ph_next_s;
    logic               wrap_ev_s;
    logic [NUM_PH-1:0]  phase_oh_s;

    // The FSM looks at the post-toggle hold value so HOLD is entered on the
    // same edge that flips hold_q; the tick of that cycle is still consumed.
    assign hold_nxt_s = hold_q_r ^ tog_hold;

    // Tick is decoded purely from flops.
    assign tick_s = (state_r == ST_RUN) && (pre_cnt_r == PRE_LAST);

    // Select the dwell field of the current phase (live, never latched).
    always_comb begin
        dwell_sel_s = '0;
        for (int p = 0; p < NUM_PH; p++) begin
            if (phase_idx_r == PH_W'(p)) begin
                dwell_sel_s = dwell_cfg[p*DWELL_W +: DWELL_W];
            end else begin
                dwell_sel_s = dwell_sel_s;
            end
        end
    end

    // A ">=" compare lets a lowered dwell setting take effect at the next tick.
    assign advance_s = tick_s && (dw_cnt_r >= dwell_sel_s);

    // Next phase index and wrap detection, using the direction before the edge.
    always_comb begin
        ph_next_s = phase_idx_r;
        wrap_ev_s = 1'b0;
        if (!dir_q_r) begin
            if (phase_idx_r == PH_LAST) begin
                ph_next_s = '0;
                wrap_ev_s = 1'b1;
            end else begin
                ph_next_s = phase_idx_r + PH_W'(1'b1);
                wrap_ev_s = 1'b0;
            end
        end else begin
            if (phase_idx_r == '0) begin
                ph_next_s = PH_LAST;
                wrap_ev_s = 1'b1;
            end else begin
                ph_next_s = phase_idx_r - PH_W'(1'b1);
                wrap_ev_s = 1'b0;
            end
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (hold_nxt_s) state_nxt_s = ST_HOLD;
                else            state_nxt_s = ST_RUN;
            end
            ST_HOLD: begin
                if (hold_nxt_s) state_nxt_s = ST_HOLD;
                else            state_nxt_s = ST_RUN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state and mode flops; the mode flops track toggles in every state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            hold_q_r <= 1'b0;
            dir_q_r  <= 1'b0;
        end else if (clr) begin
            state_r  <= ST_IDLE;
            hold_q_r <= 1'b0;
            dir_q_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            hold_q_r <= hold_nxt_s;
            dir_q_r  <= dir_q_r ^ tog_dir;
        end
    end

    // Prescaler, dwell counter, phase index and wrap pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_r   <= '0;
            dw_cnt_r    <= '0;
            phase_idx_r <= '0;
            wrap_r      <= 1'b0;
        end else if (clr) begin
            pre_cnt_r   <= '0;
            dw_cnt_r    <= '0;
            phase_idx_r <= '0;
            wrap_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (pre_cnt_r == PRE_LAST) pre_cnt_r <= '0;
                    else                       pre_cnt_r <= pre_cnt_r + PRE_W'(1'b1);
                    if (advance_s) begin
                        dw_cnt_r    <= '0;
                        phase_idx_r <= ph_next_s;
                    end else if (tick_s) begin
                        dw_cnt_r    <= dw_cnt_r + DWELL_W'(1'b1);
                    end else begin
                        dw_cnt_r    <= dw_cnt_r;
                    end
                end
                ST_HOLD: pre_cnt_r <= pre_cnt_r;
                ST_IDLE: pre_cnt_r <= '0;
                default: pre_cnt_r <= '0;
            endcase
            wrap_r <= advance_s & wrap_ev_s;
        end
    end

`ifdef SEQ_PHASE_TIMER_LAP_EN
    logic [LAP_W-1:0] lap_cnt_r;

    // Saturating count of phase wrap-arounds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lap_cnt_r <= '0;
        end else if (clr) begin
            lap_cnt_r <= '0;
        end else if (advance_s && wrap_ev_s && (lap_cnt_r != {LAP_W{1'b1}})) begin
            lap_cnt_r <= lap_cnt_r + LAP_W'(1'b1);
        end else begin
            lap_cnt_r <= lap_cnt_r;
        end
    end

    assign lap_cnt = lap_cnt_r;
`else
    assign lap_cnt = '0;
`endif

    // One-hot phase decode, blanked while idle.
    always_comb begin
        phase_oh_s = '0;
        if (state_r != ST_IDLE) begin
            phase_oh_s[phase_idx_r] = 1'b1;
        end else begin
            phase_oh_s = '0;
        end
    end

    assign phase_idx = phase_idx_r;
    assign phase_oh  = phase_oh_s;
    assign tick      = tick_s;
    assign wrap      = wrap_r;
    assign busy      = (state_r != ST_IDLE);
    assign hold_st   = (state_r == ST_HOLD);

endmodule

// File: tb/tb_seq_phase_timer.sv
// -----------------------------------------------------------------------------
// Directed bench for seq_phase_timer. A default instance (PRESCALE=10) and a
// PRESCALE=1 instance share all inputs. Cycle c counts edges after the edge
// that samples start (c=1 is the first RUN cycle); outputs are sampled 1 ns
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_seq_phase_timer;

`ifdef SEQ_PHASE_TIMER_LAP_EN
    localparam logic [7:0] LAP_ONE = 8'd1;
`else
    localparam logic [7:0] LAP_ONE = 8'd0;
`endif

    logic        clock = 1'b0;
    logic        reset_n, clr, start, tog_hold, tog_dir;
    logic [15:0] dwell_cfg;
    logic [1:0]  phase_idx, phase_idx_p1;
    logic [3:0]  phase_oh, phase_oh_p1;
    logic        tick, wrap, busy, hold_st;
    logic        tick_p1, wrap_p1, busy_p1, hold_st_p1;
    logic [7:0]  lap_cnt, lap_cnt_p1;

    int checks = 0;
    int errors = 0;
    int c = 0;

    always #5 clock = ~clock;

    seq_phase_timer u_dut (
        .clock(clock), .reset_n(reset_n), .clr(clr), .start(start),
        .tog_hold(tog_hold), .tog_dir(tog_dir), .dwell_cfg(dwell_cfg),
        .phase_idx(phase_idx), .phase_oh(phase_oh), .tick(tick), .wrap(wrap),
        .busy(busy), .hold_st(hold_st), .lap_cnt(lap_cnt)
    );

    seq_phase_timer #(.PRESCALE(1)) u_dut_p1 (
        .clock(clock), .reset_n(reset_n), .clr(clr), .start(start),
        .tog_hold(tog_hold), .tog_dir(tog_dir), .dwell_cfg(dwell_cfg),
        .phase_idx(phase_idx_p1), .phase_oh(phase_oh_p1), .tick(tick_p1), .wrap(wrap_p1),
        .busy(busy_p1), .hold_st(hold_st_p1), .lap_cnt(lap_cnt_p1)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            c = c + 1;
        end
    endtask

    // Reset both instances, then pulse start; returns positioned at c=1.
    task automatic reset_start();
        reset_n = 1'b0; clr = 1'b0; start = 1'b0; tog_hold = 1'b0; tog_dir = 1'b0;
        step(2);
        reset_n = 1'b1;
        start = 1'b1;
        c = 0;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clr = 1'b0; start = 1'b0; tog_hold = 1'b0; tog_dir = 1'b0;
        dwell_cfg = 16'h1111;
        step(2);
        checks++; if (phase_idx !== 2'd0) begin errors++; $display("FAIL reset_phase_idx got %0h exp 0", phase_idx); end
        checks++; if (phase_oh !== 4'd0) begin errors++; $display("FAIL reset_phase_oh got %0h exp 0", phase_oh); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %0b exp 0", tick); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %0b exp 0", wrap); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (hold_st !== 1'b0) begin errors++; $display("FAIL reset_hold_st got %0b exp 0", hold_st); end
        checks++; if (lap_cnt !== 8'd0) begin errors++; $display("FAIL reset_lap got %0h exp 0", lap_cnt); end
        reset_n = 1'b1;
        step(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start_busy got %0b exp 0", busy); end
    endtask

    task automatic test_basic_sequence();
        logic [1:0] exp_ph;
        logic [3:0] exp_oh;
        reset_start();
        while (c <= 90) begin
            exp_ph = 2'((c - 1) / 20);
            exp_oh = 4'b0001 << exp_ph;
            checks++; if (tick !== ((c % 10) == 0)) begin errors++; $display("FAIL basic_tick c=%0d got %0b exp %0b", c, tick, (c % 10) == 0); end
            checks++; if (phase_idx !== exp_ph) begin errors++; $display("FAIL basic_phase c=%0d got %0d exp %0d", c, phase_idx, exp_ph); end
            checks++; if (phase_oh !== exp_oh) begin errors++; $display("FAIL basic_oh c=%0d got %0h exp %0h", c, phase_oh, exp_oh); end
            checks++; if (wrap !== (c == 81)) begin errors++; $display("FAIL basic_wrap c=%0d got %0b exp %0b", c, wrap, c == 81); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy c=%0d got %0b exp 1", c, busy); end
            if (c == 81) begin
                checks++; if (lap_cnt !== LAP_ONE) begin errors++; $display("FAIL basic_lap got %0d exp %0d", lap_cnt, LAP_ONE); end
            end
            step(1);
        end
    endtask

    task automatic test_hold();
        reset_start();
        step(3);
        // c=4: pre_cnt is 3 here
        tog_hold = 1'b1;
        step(1);
        tog_hold = 1'b0;
        while (c <= 11) begin
            checks++; if (hold_st !== 1'b1) begin errors++; $display("FAIL hold_st c=%0d got %0b exp 1", c, hold_st); end
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL hold_tick c=%0d got %0b exp 0", c, tick); end
            if (c == 11) tog_hold = 1'b1;
            step(1);
            tog_hold = 1'b0;
        end
        // Seven hold cycles push the first tick from c10 to c17.
        while (c <= 17) begin
            checks++; if (hold_st !== 1'b0) begin errors++; $display("FAIL resume_hold_st c=%0d got %0b exp 0", c, hold_st); end
            checks++; if (tick !== (c == 17)) begin errors++; $display("FAIL resume_tick c=%0d got %0b exp %0b", c, tick, c == 17); end
            step(1);
        end
        checks++; if (phase_idx !== 2'd0) begin errors++; $display("FAIL hold_phase got %0d exp 0", phase_idx); end
    endtask

    task automatic test_dir();
        reset_start();
        tog_dir = 1'b1;
        step(1);
        tog_dir = 1'b0;
        step(18);
        checks++; if (phase_idx !== 2'd0 || tick !== 1'b1) begin errors++; $display("FAIL dir_pre phase=%0d tick=%0b exp 0/1", phase_idx, tick); end
        step(1);
        checks++; if (phase_idx !== 2'd3) begin errors++; $display("FAIL dir_phase got %0d exp 3", phase_idx); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL dir_wrap got %0b exp 1", wrap); end
        checks++; if (phase_oh !== 4'b1000) begin errors++; $display("FAIL dir_oh got %0h exp 8", phase_oh); end
        checks++; if (lap_cnt !== LAP_ONE) begin errors++; $display("FAIL dir_lap got %0d exp %0d", lap_cnt, LAP_ONE); end
        step(1);
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL dir_wrap_end got %0b exp 0", wrap); end
        step(19);
        checks++; if (phase_idx !== 2'd2 || wrap !== 1'b0) begin errors++; $display("FAIL dir_next phase=%0d wrap=%0b exp 2/0", phase_idx, wrap); end
    endtask

    task automatic test_clear();
        logic [1:0] exp_ph;
        reset_start();
        tog_dir = 1'b1;
        step(1);
        tog_dir = 1'b0;
        step(23);
        checks++; if (phase_idx !== 2'd3 || busy !== 1'b1) begin errors++; $display("FAIL clr_pre phase=%0d busy=%0b exp 3/1", phase_idx, busy); end
        clr = 1'b1; tog_hold = 1'b1;
        step(1);
        clr = 1'b0; tog_hold = 1'b0;
        checks++; if (busy !== 1'b0 || hold_st !== 1'b0) begin errors++; $display("FAIL clr_state busy=%0b hold=%0b exp 0/0", busy, hold_st); end
        checks++; if (phase_oh !== 4'd0 || phase_idx !== 2'd0) begin errors++; $display("FAIL clr_phase oh=%0h idx=%0d exp 0/0", phase_oh, phase_idx); end
        checks++; if (lap_cnt !== 8'd0) begin errors++; $display("FAIL clr_lap got %0d exp 0", lap_cnt); end
        c = 0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        while (c <= 21) begin
            exp_ph = 2'((c - 1) / 20);
            checks++; if (phase_idx !== exp_ph) begin errors++; $display("FAIL clr_rerun_phase c=%0d got %0d exp %0d", c, phase_idx, exp_ph); end
            checks++; if (tick !== ((c % 10) == 0)) begin errors++; $display("FAIL clr_rerun_tick c=%0d got %0b", c, tick); end
            checks++; if (hold_st !== 1'b0) begin errors++; $display("FAIL clr_rerun_hold c=%0d got %0b exp 0", c, hold_st); end
            step(1);
        end
    endtask

    task automatic test_dwell_live();
        dwell_cfg = 16'h11F1;
        reset_start();
        step(50);
        checks++; if (phase_idx !== 2'd1) begin errors++; $display("FAIL live_pre got %0d exp 1", phase_idx); end
        dwell_cfg = 16'h1101;
        step(9);
        checks++; if (phase_idx !== 2'd1 || tick !== 1'b1) begin errors++; $display("FAIL live_tick phase=%0d tick=%0b exp 1/1", phase_idx, tick); end
        step(1);
        checks++; if (phase_idx !== 2'd2) begin errors++; $display("FAIL live_advance got %0d exp 2", phase_idx); end
        dwell_cfg = 16'h1111;
    endtask

    task automatic test_async_reset();
        reset_start();
        step(24);
        tog_hold = 1'b1;
        step(1);
        tog_hold = 1'b0;
        checks++; if (hold_st !== 1'b1 || phase_idx !== 2'd1) begin errors++; $display("FAIL ar_pre hold=%0b phase=%0d exp 1/1", hold_st, phase_idx); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (phase_idx !== 2'd0 || phase_oh !== 4'd0) begin errors++; $display("FAIL ar_phase idx=%0d oh=%0h exp 0/0", phase_idx, phase_oh); end
        checks++; if (busy !== 1'b0 || hold_st !== 1'b0) begin errors++; $display("FAIL ar_state busy=%0b hold=%0b exp 0/0", busy, hold_st); end
        checks++; if (tick !== 1'b0 || wrap !== 1'b0 || lap_cnt !== 8'd0) begin errors++; $display("FAIL ar_misc tick=%0b wrap=%0b lap=%0d exp 0", tick, wrap, lap_cnt); end
        checks++; if (busy_p1 !== 1'b0 || phase_idx_p1 !== 2'd0) begin errors++; $display("FAIL ar_p1 busy=%0b idx=%0d exp 0/0", busy_p1, phase_idx_p1); end
        reset_n = 1'b1;
    endtask

    task automatic test_prescale1();
        logic [1:0] exp_ph;
        reset_start();
        while (c <= 10) begin
            exp_ph = 2'((c - 1) / 2);
            checks++; if (tick_p1 !== 1'b1) begin errors++; $display("FAIL p1_tick c=%0d got %0b exp 1", c, tick_p1); end
            checks++; if (phase_idx_p1 !== exp_ph) begin errors++; $display("FAIL p1_phase c=%0d got %0d exp %0d", c, phase_idx_p1, exp_ph); end
            checks++; if (wrap_p1 !== (c == 9)) begin errors++; $display("FAIL p1_wrap c=%0d got %0b exp %0b", c, wrap_p1, c == 9); end
            step(1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_sequence();
        test_hold();
        test_dir();
        test_clear();
        test_dwell_live();
        test_async_reset();
        test_prescale1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
